// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master: round-robin arbitration between fetch and
// load/store ports, one single-beat AXI transaction per accepted request.
module axi_master_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_resp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [2:0]            lsu_size,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_resp_err,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [3:0]            arid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [3:0]            rid,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [3:0]            awid,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [3:0]            bid,
    input  logic [1:0]            bresp
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_e;

    state_e              state_q, state_d;
    logic                last_lsu_q, last_lsu_d;
    logic                src_lsu_q, src_lsu_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                arvalid_q, arvalid_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                ifu_rv_q, ifu_rv_d;
    logic                lsu_rv_q, lsu_rv_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                grant_lsu, grant_ifu, idle;

    // AXI ID/last fields are fixed by the single-beat, single-outstanding scheme
    logic unused_inputs;
    assign unused_inputs = ^{rid, rlast, bid};

    always_comb begin
        idle       = (state_q == S_IDLE);
        grant_lsu  = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
        grant_ifu  = ifu_req_valid && !grant_lsu;
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        src_lsu_d  = src_lsu_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ifu_rv_d   = 1'b0;
        lsu_rv_d   = 1'b0;
        case (state_q)
            S_IDLE: if (grant_lsu || grant_ifu) begin
                last_lsu_d = grant_lsu;
                src_lsu_d  = grant_lsu;
                addr_d     = grant_lsu ? lsu_addr : ifu_addr;
                size_d     = grant_lsu ? lsu_size : 3'b010;
                wdata_d    = grant_lsu ? lsu_wdata : '0;
                wstrb_d    = grant_lsu ? lsu_wstrb : '0;
                if (grant_lsu && lsu_wen) begin
                    state_d   = S_WR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    state_d   = S_AR;
                    arvalid_d = 1'b1;
                end
            end
            S_AR: if (arready) begin
                arvalid_d = 1'b0;
                state_d   = S_R;
            end
            S_R: if (rvalid) begin
                rdata_d  = rdata;
                err_d    = (rresp != 2'b00);
                ifu_rv_d = !src_lsu_q;
                lsu_rv_d = src_lsu_q;
                state_d  = S_IDLE;
            end
            S_WR: begin
                // AW and W retire independently; leave once neither is pending
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = S_B;
            end
            S_B: if (bvalid) begin
                err_d    = (bresp != 2'b00);
                ifu_rv_d = !src_lsu_q;
                lsu_rv_d = src_lsu_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            last_lsu_q <= 1'b0;
            src_lsu_q  <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            ifu_rv_q   <= 1'b0;
            lsu_rv_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
            src_lsu_q  <= src_lsu_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            arvalid_q  <= arvalid_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            ifu_rv_q   <= ifu_rv_d;
            lsu_rv_q   <= lsu_rv_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Ready is held low while reset is asserted so nothing is accepted then
    assign ifu_req_ready  = aresetn && idle && grant_ifu;
    assign lsu_req_ready  = aresetn && idle && grant_lsu;
    assign ifu_resp_valid = ifu_rv_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;
    assign ifu_resp_err   = ifu_rv_q && err_q;
    assign lsu_resp_err   = lsu_rv_q && err_q;

    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arid    = {3'b000, src_lsu_q};
    assign arlen   = 8'd0;
    assign arsize  = size_q;
    assign arburst = 2'b01;
    assign rready  = (state_q == S_R);
    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awid    = 4'd1;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = 2'b01;
    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign bready  = (state_q == S_B);

endmodule

// File: tb/tb_axi_master_bridge.sv
// Randomized bench: behavioural requesters, a simple AXI slave memory and a
// transaction-level reference model of arbitration, data and error results.
module tb_axi_master_bridge;
    logic aclk = 1'b0, aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr;
    logic [63:0] ifu_rdata;
    logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr;
    logic [2:0]  lsu_size;
    logic [63:0] lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wstrb;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr;
    logic [3:0]  arid, rid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic [63:0] rdata;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr;
    logic [3:0]  awid, bid;
    logic [7:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic [63:0] wdata;

    axi_master_bridge #(.ADDR_W(32), .DATA_W(64)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    int nvec = 0, nerr = 0, cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model and slave memories (independent copies)
    logic [63:0] rmem [logic [28:0]];
    logic [63:0] smem [logic [28:0]];
    bit busy, c_lsu, c_wen, c_err, m_last_lsu;
    logic [31:0] c_addr;
    logic [2:0]  c_size;
    logic [63:0] c_wdata, c_exp;
    logic [7:0]  c_wstrb;
    int acc_cyc, resp_cnt, b_cnt;
    logic [63:0] last_ifu_rd, last_lsu_rd;
    bit last_lsu_err;
    // slave state
    bit rd_pend, b_pend, aw_done, w_done;
    logic [31:0] s_araddr, s_awaddr;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    int skew_cnt;
    // stimulus control
    bit zero_wait, skew_w, rnd_req, cont_mode, ifu_hs, lsu_hs, ifu_want, lsu_want, n_wen;
    logic [31:0] n_ifu_addr, n_lsu_addr;
    logic [2:0]  n_size;
    logic [63:0] n_wdata;
    logic [7:0]  n_wstrb;
    int cgrants;
    logic [3:0] cseq;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] rd_ref(input logic [31:0] a);
        return rmem.exists(a[31:3]) ? rmem[a[31:3]] : 64'd0;
    endfunction

    function automatic logic [63:0] rd_slv(input logic [31:0] a);
        return smem.exists(a[31:3]) ? smem[a[31:3]] : 64'd0;
    endfunction

    function automatic logic [31:0] raddr();
        logic [3:0] idx = 4'($urandom_range(0, 15));
        logic [3:0] top = ($urandom_range(0, 7) == 0) ? 4'hF : 4'h8;
        return {top, 21'd0, idx, 3'b000};
    endfunction

    task automatic cycle();
        @(negedge aclk);
        // responses
        if (ifu_resp_valid || lsu_resp_valid) begin
            resp_cnt++;
            chk("resp_expected", busy, 1);
            chk("resp_one_port", ifu_resp_valid & lsu_resp_valid, 0);
            chk("resp_port", lsu_resp_valid, c_lsu);
            if (busy) begin
                chk("resp_err", c_lsu ? lsu_resp_err : ifu_resp_err, c_err);
                if (!c_wen) chk("resp_data", c_lsu ? lsu_rdata : ifu_rdata, c_exp);
                if (zero_wait && !skew_w) chk("resp_latency", cyc - acc_cyc, 3);
            end
            if (ifu_resp_valid) last_ifu_rd = ifu_rdata;
            if (lsu_resp_valid) begin last_lsu_rd = lsu_rdata; last_lsu_err = lsu_resp_err; end
            busy = 0;
        end
        if (awvalid || wvalid) begin
            if (!aw_done && !w_done) chk("aw_w_together", awvalid, wvalid);
            if (aw_done) chk("aw_dropped", awvalid, 0);
            if (w_done)  chk("w_dropped", wvalid, 0);
        end
        // slave
        arready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
        awready = (zero_wait || skew_w) ? 1'b1 : 1'($urandom_range(0, 1));
        if (skew_w) begin
            wready = (skew_cnt >= 3);
            if (wvalid) skew_cnt++;
        end else wready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
        if (rd_pend) begin
            if (!rvalid) rvalid = zero_wait || ($urandom_range(0, 2) == 0);
        end else rvalid = 1'b0;
        rdata = rd_slv(s_araddr);
        rresp = (s_araddr[31:28] == 4'hF) ? 2'b10 : 2'b00;
        rid   = 4'($urandom);
        rlast = 1'($urandom);
        if (b_pend) begin
            if (!bvalid) bvalid = zero_wait || ($urandom_range(0, 2) == 0);
        end else bvalid = 1'b0;
        bresp = (s_awaddr[31:28] == 4'hF) ? 2'b10 : 2'b00;
        bid   = 4'($urandom);
        // requesters
        if (ifu_hs) ifu_req_valid = 0;
        if (lsu_hs) lsu_req_valid = 0;
        ifu_hs = 0; lsu_hs = 0;
        if (!ifu_req_valid && (ifu_want || cont_mode || (rnd_req && $urandom_range(0, 3) == 0))) begin
            ifu_req_valid = 1;
            ifu_addr = ifu_want ? n_ifu_addr : raddr();
            ifu_want = 0;
        end
        if (!lsu_req_valid && (lsu_want || cont_mode || (rnd_req && $urandom_range(0, 3) == 0))) begin
            lsu_req_valid = 1;
            if (lsu_want) begin
                lsu_wen = n_wen; lsu_addr = n_lsu_addr; lsu_size = n_size;
                lsu_wdata = n_wdata; lsu_wstrb = n_wstrb;
            end else begin
                lsu_wen = cont_mode ? 1'b0 : 1'($urandom);
                lsu_addr = raddr(); lsu_size = 3'($urandom_range(0, 3));
                lsu_wdata = {$urandom, $urandom}; lsu_wstrb = 8'($urandom);
            end
            lsu_want = 0;
        end
        #1;
        // handshakes about to happen at the next rising edge
        ifu_hs = ifu_req_valid & ifu_req_ready;
        lsu_hs = lsu_req_valid & lsu_req_ready;
        if (ifu_req_ready || lsu_req_ready) begin
            bit exp_lsu;
            chk("ready_when_idle", busy, 0);
            exp_lsu = lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
            chk("grant_lsu", lsu_req_ready, exp_lsu);
            chk("grant_ifu", ifu_req_ready, !exp_lsu);
            if (cont_mode && cgrants < 4) begin cseq = {cseq[2:0], lsu_req_ready}; cgrants++; end
            m_last_lsu = exp_lsu;
            busy = 1; acc_cyc = cyc; c_lsu = exp_lsu;
            c_addr  = exp_lsu ? lsu_addr : ifu_addr;
            c_wen   = exp_lsu && lsu_wen;
            c_size  = exp_lsu ? lsu_size : 3'd2;
            c_wdata = lsu_wdata; c_wstrb = lsu_wstrb;
            c_err   = (c_addr[31:28] == 4'hF);
            if (c_wen) rmem[c_addr[31:3]] = merge(rd_ref(c_addr), c_wdata, c_wstrb);
            else c_exp = rd_ref(c_addr);
        end
        if (arvalid && arready) begin
            chk("ar_is_read", c_wen, 0);
            chk("araddr", araddr, c_addr);
            chk("arid", arid, {3'b0, c_lsu});
            chk("arsize", arsize, c_size);
            chk("arlen_burst", {arlen, arburst}, {8'd0, 2'b01});
            rd_pend = 1; s_araddr = araddr;
        end
        if (rvalid && rready) rd_pend = 0;
        if (awvalid && awready) begin
            chk("aw_is_write", c_wen, 1);
            chk("awaddr", awaddr, c_addr);
            chk("aw_fields", {awid, awlen, awsize, awburst}, {4'd1, 8'd0, c_size, 2'b01});
            aw_done = 1; s_awaddr = awaddr;
        end
        if (wvalid && wready) begin
            chk("wdata", wdata, c_wdata);
            chk("wstrb_wlast", {wstrb, wlast}, {c_wstrb, 1'b1});
            w_done = 1; s_wdata = wdata; s_wstrb = wstrb;
        end
        if (aw_done && w_done) begin
            smem[s_awaddr[31:3]] = merge(rd_slv(s_awaddr), s_wdata, s_wstrb);
            b_pend = 1; aw_done = 0; w_done = 0;
        end
        if (bvalid && bready) begin b_pend = 0; b_cnt++; end
    endtask

    task automatic drain(input int max);
        int n = 0;
        do begin cycle(); n++; end
        while ((busy || ifu_req_valid || lsu_req_valid || ifu_want || lsu_want || rd_pend || b_pend) && n < max);
        if (n >= max) chk("drain_timeout", {busy, ifu_req_valid, lsu_req_valid, rd_pend, b_pend}, 0);
    endtask

    task automatic lsu_go(input bit w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        lsu_want = 1; n_wen = w; n_lsu_addr = a; n_size = 3'd3; n_wdata = d; n_wstrb = s;
        drain(60);
    endtask

    function automatic logic [10:0] ctl_outs();
        return {arvalid, awvalid, wvalid, rready, bready, ifu_req_ready, lsu_req_ready,
                ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err};
    endfunction

    initial begin
        int n, rc, bc;
        {ifu_addr, lsu_wen, lsu_addr, lsu_size, lsu_wdata, lsu_wstrb} = '0;
        {arready, rvalid, rdata, rid, rresp, rlast, awready, wready, bvalid, bid, bresp} = '0;
        ifu_req_valid = 1; lsu_req_valid = 1;
        repeat (2) @(negedge aclk);
        #1;
        chk("reset_ctl", ctl_outs(), 0);
        chk("reset_rdata", ifu_rdata, 0);
        chk("reset_addr", {araddr, awaddr}, 0);
        ifu_req_valid = 0; lsu_req_valid = 0;
        @(negedge aclk) aresetn = 1;

        // single fetch, zero-wait slave
        zero_wait = 1;
        smem[29'h1000_0000] = 64'h00000413_00000297;
        rmem[29'h1000_0000] = 64'h00000413_00000297;
        ifu_want = 1; n_ifu_addr = 32'h8000_0000;
        drain(40);
        chk("fetch_rdata", last_ifu_rd, 64'h00000413_00000297);

        // store then readback
        lsu_go(1, 32'h8000_1000, 64'h1122334455667788, 8'h0F);
        lsu_go(0, 32'h8000_1000, 64'h0, 8'h0);
        chk("store_readback_lo", last_lsu_rd[31:0], 32'h55667788);

        // skewed W channel
        skew_w = 1; skew_cnt = 0; rc = resp_cnt; bc = b_cnt;
        lsu_go(1, 32'h8000_1008, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        skew_w = 0;
        chk("skew_b_count", b_cnt - bc, 1);
        chk("skew_resp_count", resp_cnt - rc, 1);

        // error response on a load
        lsu_go(0, 32'hF000_0040, 64'h0, 8'h0);
        chk("load_err", last_lsu_err, 1);

        // reset while R has rvalid pending
        ifu_want = 1; n_ifu_addr = 32'h8000_0040;
        n = 0;
        while (!rd_pend && n < 20) begin cycle(); n++; end
        chk("midR_reached", rd_pend, 1);
        @(negedge aclk);
        rvalid = 1; rdata = 64'hDEAD_BEEF_0000_0001; rresp = 2'b00;
        #1 aresetn = 0;
        #1 chk("midR_reset_ctl", ctl_outs(), 0);
        rvalid = 0; rd_pend = 0; busy = 0; m_last_lsu = 0;
        ifu_req_valid = 0; lsu_req_valid = 0; ifu_hs = 0; lsu_hs = 0;
        rc = resp_cnt;
        repeat (3) cycle();
        chk("midR_no_resp", resp_cnt, rc);
        @(negedge aclk) aresetn = 1;
        ifu_want = 1; n_ifu_addr = 32'h8000_0000;
        drain(40);
        chk("post_reset_fetch", last_ifu_rd, 64'h00000413_00000297);

        // contention: both ports continuously valid
        cont_mode = 1; cgrants = 0; cseq = '0; n = 0;
        while (cgrants < 4 && n < 100) begin cycle(); n++; end
        cont_mode = 0;
        drain(60);
        chk("contention_order", cseq, 4'b1010);

        // randomized traffic with random slave readiness
        zero_wait = 0; rnd_req = 1;
        repeat (800) cycle();
        rnd_req = 0;
        drain(300);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
